// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter sizing for the piso transmitter
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} piso_state_t;
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable zero-fill shift register with a direction-selected serial tap
module piso_shreg #(
    parameter int N         = 32,
    parameter bit LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] d,
    output logic         sout
);
    logic [N-1:0] q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= LSB_FIRST ? {1'b0, q[N-1:1]} : {q[N-2:0], 1'b0};
    assign sout = LSB_FIRST ? q[0] : q[N-1];
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with valid/ready intake and back-to-back reload
module piso_tx
    import piso_pkg::*;
#(
    parameter int N         = 32,
    parameter bit LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    input  logic         d_valid,
    output logic         d_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);
    localparam int CW = cnt_w(N);
    piso_state_t   state, state_d;
    logic [CW-1:0] cnt;
    logic          last, accept, tap;
    assign last    = state == SHIFT && cnt == '0;
    assign d_ready = rst && (state == IDLE || last);
    assign accept  = en && d_valid && d_ready;
    always_comb begin
        state_d = state;
        if (en)
            state_d = state == IDLE ? (d_valid ? SHIFT : IDLE) : (last && !d_valid ? IDLE : SHIFT);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (accept) cnt <= CW'(N - 1);
            else if (en && state == SHIFT && !last) cnt <= cnt - 1'b1;
        end
    // a reload on the final bit replaces the shift so the new word starts intact
    piso_shreg #(.N(N), .LSB_FIRST(LSB_FIRST)) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(en && state == SHIFT && !accept),
        .d    (d),
        .sout (tap)
    );
    assign busy       = state == SHIFT;
    assign sout_valid = busy;
    assign sout       = busy && tap;
    assign done       = last;
endmodule
